// File: rtl/pslip_pkg.sv
`default_nettype none
// ============================================================
// Package : pslip_pkg
// Shared sizes, types and FSM encoding for the pSLIP grant stage.
// Revision: 1.0
// ============================================================
package pslip_pkg;

    localparam int PSLIP_N    = 8;
    localparam int PSLIP_P    = 16;
    localparam int PSLIP_ITER = 4;
    localparam int PSLIP_PW   = (PSLIP_P > 1) ? $clog2(PSLIP_P) : 1;
    localparam int PSLIP_IW   = (PSLIP_N > 1) ? $clog2(PSLIP_N) : 1;

    typedef logic [PSLIP_PW-1:0] pri_t;
    typedef logic [PSLIP_IW-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        MATCHED   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pslip_rr_pick.sv
`default_nettype none
// ============================================================
// Module : pslip_rr_pick
// Combinational round-robin picker: first request at or after ptr.
// Revision: 1.0
// ============================================================
module pslip_rr_pick #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_mask;

    // The doubled vector lets a single ascending scan over [ptr, ptr+N) cover the wrap.
    always_comb begin
        w_dbl  = {req, req};
        w_mask = '0;
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = 0; k < 2*N; k++) begin
            w_mask[k] = (k >= int'(ptr)) && (k < int'(ptr) + N);
        end
        for (int k = 0; k < 2*N; k++) begin
            if (!any && w_dbl[k] && w_mask[k]) begin
                any = 1'b1;
                idx = (k >= N) ? IW'(k - N) : IW'(k);
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pslip_grant_arb.sv
`default_nettype none
// ============================================================
// Module : pslip_grant_arb
// Per-output-port pSLIP grant stage: registered RR grant, hold until response.
// Revision: 1.0
// ============================================================
module pslip_grant_arb
    import pslip_pkg::*;
#(
    parameter int N    = PSLIP_N,
    parameter int P    = PSLIP_P,
    parameter int ITER = PSLIP_ITER,
    localparam int PW  = (P > 1) ? $clog2(P) : 1,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          slot_start,
    input  logic          req_valid,
    input  logic [N-1:0]  req_in,
    input  logic [PW-1:0] pri_in,
    input  logic          resp_valid,
    input  logic          resp_accept,
    output logic          grant_valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic [PW-1:0] grant_pri,
    output logic          matched,
    output logic [IW-1:0] ptr
);

    localparam int CW = $clog2(ITER + 1);

    state_t        state_q,       state_d;
    logic [IW-1:0] ptr_q,         ptr_d;
    logic [CW-1:0] iter_q,        iter_d;
    logic          grant_valid_q, grant_valid_d;
    logic [N-1:0]  grant_q,       grant_d;
    logic [IW-1:0] grant_idx_q,   grant_idx_d;
    logic [PW-1:0] grant_pri_q,   grant_pri_d;
    logic          matched_q,     matched_d;

    logic [N-1:0]  w_pick_onehot;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_any;

    pslip_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req    (req_in),
        .ptr    (ptr_q),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .any    (w_pick_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        iter_d        = iter_q;
        grant_valid_d = grant_valid_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_pri_d   = grant_pri_q;
        matched_d     = matched_q;

        // A new slot wins over anything else, including a coincident response.
        if (slot_start) begin
            state_d       = IDLE;
            iter_d        = '0;
            matched_d     = 1'b0;
            grant_valid_d = 1'b0;
            grant_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && w_pick_any && (iter_q < CW'(ITER))) begin
                        state_d       = WAIT_RESP;
                        grant_valid_d = 1'b1;
                        grant_d       = w_pick_onehot;
                        grant_idx_d   = w_pick_idx;
                        grant_pri_d   = pri_in;
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        grant_valid_d = 1'b0;
                        grant_d       = '0;
                        if (resp_accept) begin
                            state_d   = MATCHED;
                            matched_d = 1'b1;
                            // Only a first-iteration accept advances the pointer (iSLIP rule).
                            if (iter_q == '0) begin
                                ptr_d = (grant_idx_q == IW'(N - 1)) ? '0 : grant_idx_q + IW'(1);
                            end
                        end else begin
                            state_d = IDLE;
                            if (iter_q != CW'(ITER)) begin
                                iter_d = iter_q + CW'(1);
                            end
                        end
                    end
                end
                MATCHED: begin
                    matched_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            iter_q        <= '0;
            grant_valid_q <= 1'b0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_pri_q   <= '0;
            matched_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            iter_q        <= iter_d;
            grant_valid_q <= grant_valid_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_pri_q   <= grant_pri_d;
            matched_q     <= matched_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_pri   = grant_pri_q;
    assign matched     = matched_q;
    assign ptr         = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_pslip_grant_arb.sv
`default_nettype none
// ============================================================
// Module : tb_pslip_grant_arb
// Scoreboard bench for pslip_grant_arb (ITER=2 instance).
// Revision: 1.0
// ============================================================
module tb_pslip_grant_arb;
    import pslip_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slot_start = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_in = '0;
    logic [3:0] pri_in = '0;
    logic       resp_valid = 1'b0;
    logic       resp_accept = 1'b0;
    logic       grant_valid;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic [3:0] grant_pri;
    logic       matched;
    logic [2:0] ptr;

    pslip_grant_arb #(.N(8), .P(16), .ITER(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_start  (slot_start),
        .req_valid   (req_valid),
        .req_in      (req_in),
        .pri_in      (pri_in),
        .resp_valid  (resp_valid),
        .resp_accept (resp_accept),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_pri   (grant_pri),
        .matched     (matched),
        .ptr         (ptr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        idx_t idx;
        pri_t pri;
    } exp_grant_t;

    exp_grant_t exp_grants[$];
    int         exp_ptrs[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare each new grant and each new match against the scoreboard.
    logic prev_gv = 1'b0;
    logic prev_m  = 1'b0;
    always @(negedge clk) begin
        if (grant_valid === 1'b1 && prev_gv !== 1'b1) begin
            if (exp_grants.size() == 0) begin
                check("unexpected_grant_idx", int'(grant_idx), -1);
            end else begin
                exp_grant_t e;
                logic [7:0] oh;
                e = exp_grants.pop_front();
                oh = 8'b1 << e.idx;
                check("grant_idx", int'(grant_idx), int'(e.idx));
                check("grant_vec", int'(grant), int'(oh));
                check("grant_pri", int'(grant_pri), int'(e.pri));
            end
        end
        if (matched === 1'b1 && prev_m !== 1'b1) begin
            if (exp_ptrs.size() == 0) begin
                check("unexpected_match_ptr", int'(ptr), -1);
            end else begin
                int ep;
                ep = exp_ptrs.pop_front();
                check("match_ptr", int'(ptr), ep);
                check("match_gv_low", int'(grant_valid), 0);
            end
        end
        prev_gv = grant_valid;
        prev_m  = matched;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_slot();
        slot_start = 1'b1;
        tick();
        slot_start = 1'b0;
        tick();
    endtask

    task automatic do_req(input logic [7:0] r, input logic [3:0] p, input int exp_idx);
        exp_grant_t e;
        req_valid = 1'b1;
        req_in    = r;
        pri_in    = p;
        if (exp_idx >= 0) begin
            e.idx = idx_t'(exp_idx);
            e.pri = p;
            exp_grants.push_back(e);
        end
        tick();
        req_valid = 1'b0;
        req_in    = '0;
        tick();
    endtask

    task automatic do_resp(input logic acc, input int exp_ptr);
        resp_valid  = 1'b1;
        resp_accept = acc;
        if (acc) exp_ptrs.push_back(exp_ptr);
        tick();
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gv"},      int'(grant_valid), 0);
        check({tag, "_grant"},   int'(grant), 0);
        check({tag, "_idx"},     int'(grant_idx), 0);
        check({tag, "_pri"},     int'(grant_pri), 0);
        check({tag, "_matched"}, int'(matched), 0);
        check({tag, "_ptr"},     int'(ptr), 0);
    endtask

    initial begin
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic grant, then rotation.
        do_slot();
        do_req(8'b0010_0100, 4'd5, 2);
        do_resp(1'b1, 3);
        do_slot();
        do_req(8'b0010_0100, 4'd9, 5);
        do_resp(1'b1, 6);

        // Requests/responses ignored while matched.
        do_req(8'b1111_1111, 4'd1, -1);
        check("matched_hold_gv", int'(grant_valid), 0);
        check("matched_hold", int'(matched), 1);

        // Wrap-around from ptr=7.
        do_slot();
        do_req(8'b0100_0000, 4'd1, 6);
        do_resp(1'b1, 7);
        do_slot();
        do_req(8'b0000_0011, 4'd2, 0);
        do_resp(1'b1, 1);

        // Later-iteration accept keeps ptr.
        do_slot();
        do_req(8'b1000_0000, 4'd3, 7);
        do_resp(1'b1, 0);
        do_slot();
        do_req(8'b0000_0000, 4'd3, -1);
        check("zero_req_no_grant", int'(grant_valid), 0);
        do_req(8'b0000_0110, 4'd3, 1);
        do_resp(1'b0, 0);
        check("reject_gv", int'(grant_valid), 0);
        check("reject_grant", int'(grant), 0);
        do_req(8'b0000_0100, 4'd4, 2);
        do_resp(1'b1, 0);

        // Iteration limit with ITER=2.
        do_slot();
        do_req(8'b0000_0001, 4'd1, 0);
        do_resp(1'b0, 0);
        do_req(8'b0000_0001, 4'd1, 0);
        do_resp(1'b0, 0);
        do_req(8'b0000_0001, 4'd1, -1);
        check("iter_limit_gv", int'(grant_valid), 0);

        // slot_start beats a coincident accept.
        do_slot();
        do_req(8'b0001_0000, 4'd2, 4);
        slot_start  = 1'b1;
        resp_valid  = 1'b1;
        resp_accept = 1'b1;
        tick();
        slot_start  = 1'b0;
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        check("collide_matched", int'(matched), 0);
        check("collide_ptr", int'(ptr), 0);
        check("collide_gv", int'(grant_valid), 0);
        tick();
        do_req(8'b0000_1000, 4'd6, 3);
        do_resp(1'b1, 4);

        // Reset during WAIT_RESP.
        do_slot();
        do_req(8'b0000_0001, 4'd7, 0);
        check("pre_reset_ptr", int'(ptr), 4);
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n = 1'b1;
        resp_valid  = 1'b1;
        resp_accept = 1'b1;
        tick();
        resp_valid  = 1'b0;
        resp_accept = 1'b0;
        tick();
        check("post_reset_resp_matched", int'(matched), 0);
        check("post_reset_resp_ptr", int'(ptr), 0);

        // slot_start with req_valid: request is not granted that cycle.
        slot_start = 1'b1;
        req_valid  = 1'b1;
        req_in     = 8'b0000_0010;
        tick();
        slot_start = 1'b0;
        req_valid  = 1'b0;
        req_in     = '0;
        tick();
        check("slot_req_same_cycle_gv", int'(grant_valid), 0);
        do_req(8'b0000_0010, 4'd8, 1);
        do_resp(1'b1, 2);
        tick();

        check("leftover_grants", exp_grants.size(), 0);
        check("leftover_matches", exp_ptrs.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
